// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter granting one requester at a time ownership of a shared mux_switch path.
// Define MUX_ARB_GAP_EN to insert one break-before-make idle cycle on every handoff.
module mux_rr_arbiter #(
   parameter int N        = 4,
   parameter int SEL_W    = 2,
   parameter int MAX_HOLD = 8,
   parameter int CNT_W    = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     req,
   output logic [N-1:0]     grant,
   output logic [SEL_W-1:0] sel,
   output logic             busy,
   output logic             timeout,
   output logic [1:0]       dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_OWN  = 2'd1,
      S_GAP  = 2'd2
   } state_t;

   state_t             r_state;
   logic [N-1:0]       r_grant;
   logic [SEL_W-1:0]   r_sel;
   logic [SEL_W-1:0]   r_last;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_timeout;

   state_t             w_state_nxt;
   logic [N-1:0]       w_grant_nxt;
   logic [SEL_W-1:0]   w_sel_nxt;
   logic [SEL_W-1:0]   w_last_nxt;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic               w_timeout_nxt;

   logic               w_any;
   logic               w_owner_req;
   logic               w_hi_found;
   logic               w_lo_found;
   logic [SEL_W-1:0]   w_hi;
   logic [SEL_W-1:0]   w_lo;
   logic [SEL_W-1:0]   w_win;
   logic [N-1:0]       w_win_oh;
   logic               w_take;
   logic               w_handoff;

   // Rotating priority: first request above r_last wins, else first at or below it.
   always_comb begin
      w_any       = |req;
      w_owner_req = 1'b0;
      w_hi_found  = 1'b0;
      w_lo_found  = 1'b0;
      w_hi        = '0;
      w_lo        = '0;
      for (int k = 0; k < N; k++) begin
         if (req[k] && !w_hi_found && (k > int'(r_last))) begin
            w_hi_found = 1'b1;
            w_hi       = SEL_W'(k);
         end
         if (req[k] && !w_lo_found && (k <= int'(r_last))) begin
            w_lo_found = 1'b1;
            w_lo       = SEL_W'(k);
         end
         if (k == int'(r_last)) w_owner_req = req[k];
      end
      w_win    = w_hi_found ? w_hi : w_lo;
      w_win_oh = N'(1) << w_win;
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_grant_nxt   = r_grant;
      w_sel_nxt     = r_sel;
      w_last_nxt    = r_last;
      w_cnt_nxt     = r_cnt;
      w_timeout_nxt = 1'b0;
      w_take        = 1'b0;
      w_handoff     = 1'b0;

      case (r_state)
         S_OWN: begin
            // A dropped request releases quietly even when the hold limit is reached.
            if (!w_owner_req) begin
               w_handoff = 1'b1;
            end else if (r_cnt == CNT_W'(MAX_HOLD)) begin
               w_handoff     = 1'b1;
               w_timeout_nxt = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         default: w_take = w_any;
      endcase

`ifdef MUX_ARB_GAP_EN
      if (w_handoff) begin
         w_state_nxt = S_GAP;
         w_grant_nxt = '0;
         w_cnt_nxt   = '0;
      end else if ((r_state == S_GAP) && !w_any) begin
         w_state_nxt = S_IDLE;
      end
`else
      if (w_handoff) begin
         if (w_any) begin
            w_take = 1'b1;
         end else begin
            w_state_nxt = S_IDLE;
            w_grant_nxt = '0;
            w_cnt_nxt   = '0;
         end
      end
`endif

      if (w_take) begin
         w_state_nxt = S_OWN;
         w_grant_nxt = w_win_oh;
         w_sel_nxt   = w_win;
         w_last_nxt  = w_win;
         w_cnt_nxt   = CNT_W'(1);
      end
   end

   // r_last starts at N-1 so requester 0 has top priority after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_grant   <= '0;
         r_sel     <= '0;
         r_last    <= SEL_W'(N - 1);
         r_cnt     <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_grant   <= w_grant_nxt;
         r_sel     <= w_sel_nxt;
         r_last    <= w_last_nxt;
         r_cnt     <= w_cnt_nxt;
         r_timeout <= w_timeout_nxt;
      end
   end

   assign grant     = r_grant;
   assign sel       = r_sel;
   assign busy      = |r_grant;
   assign timeout   = r_timeout;
   assign dbg_state = r_state;

endmodule
